// File: rtl/gray_ptr_monitor.sv
`default_nettype none
// ============================================================================
// Module   : gray_ptr_monitor
// Purpose  : Receive-side monitor for a Gray-coded pointer stream. Decodes
//            each sample to binary, classifies it against the previously
//            accepted sample (hold / step-up / step-down / illegal jump) and
//            keeps a saturating count of illegal jumps.
// Revision : 1.0 - initial release
// ============================================================================
module gray_ptr_monitor #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_gray,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_bin,
    output logic                  out_hold,
    output logic                  out_up,
    output logic                  out_down,
    output logic                  err_jump,
    output logic [7:0]            err_count,
    output logic                  locked
);

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE       = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]            COUNT_MAX = 8'hFF;

    state_t                  state;
    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_gray;
    logic [DATA_WIDTH-1:0]   s1_bin;
    logic [DATA_WIDTH-1:0]   ref_gray;
    logic [DATA_WIDTH-1:0]   ref_bin;
    logic [DATA_WIDTH-1:0]   gray_diff;
    logic [5:0]              diff_count;
    logic                    is_step_up;

    // Stage 1: capture the incoming sample; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_gray  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_gray  <= in_gray;
        end
    end

    // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        s1_bin = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            s1_bin[i] = ^(s1_gray >> i);
        end
    end

    // Hamming distance between the staged sample and the reference
    always_comb begin
        gray_diff  = s1_gray ^ ref_gray;
        diff_count = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            diff_count = diff_count + {5'd0, gray_diff[i]};
        end
    end

    // A single-bit change is either +1 or -1 (mod 2^W); only +1 needs an explicit test
    assign is_step_up = (s1_bin == (ref_bin + ONE));

    // Stage 2: classify against the reference, update outputs, reference and state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEEK;
            ref_gray  <= '0;
            ref_bin   <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_hold  <= 1'b0;
            out_up    <= 1'b0;
            out_down  <= 1'b0;
            err_jump  <= 1'b0;
            err_count <= '0;
            locked    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_hold  <= 1'b0;
            out_up    <= 1'b0;
            out_down  <= 1'b0;
            err_jump  <= 1'b0;
            if (s1_valid) begin
                out_valid <= 1'b1;
                out_bin   <= s1_bin;
                // Every accepted sample becomes the reference, including jumps (resync)
                ref_gray  <= s1_gray;
                ref_bin   <= s1_bin;
                case (state)
                    SEEK: begin
                        // First sample only establishes the reference; it is never classified
                        state  <= LOCK;
                        locked <= 1'b1;
                    end
                    LOCK: begin
                        if (diff_count == 6'd0) begin
                            out_hold <= 1'b1;
                        end else if (diff_count == 6'd1) begin
                            if (is_step_up) begin
                                out_up <= 1'b1;
                            end else begin
                                out_down <= 1'b1;
                            end
                        end else begin
                            err_jump <= 1'b1;
                            if (err_count != COUNT_MAX) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= SEEK;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_ptr_monitor
// Purpose  : Directed self-checking bench for gray_ptr_monitor (DATA_WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_ptr_monitor;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_gray;
    logic       out_valid;
    logic [3:0] out_bin;
    logic       out_hold;
    logic       out_up;
    logic       out_down;
    logic       err_jump;
    logic [7:0] err_count;
    logic       locked;

    int checks;
    int errors;

    gray_ptr_monitor #(.DATA_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_gray   (in_gray),
        .out_valid (out_valid),
        .out_bin   (out_bin),
        .out_hold  (out_hold),
        .out_up    (out_up),
        .out_down  (out_down),
        .err_jump  (err_jump),
        .err_count (err_count),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {valid, bin[3:0], hold, up, down, jump}
    function automatic logic [8:0] obs();
        return {out_valid, out_bin, out_hold, out_up, out_down, err_jump};
    endfunction

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle of input; afterwards the outputs show the previous cycle's sample
    task automatic step(input logic v, input logic [3:0] g);
        in_valid = v;
        in_gray  = g;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== 9'b0_0000_0000 || locked !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got obs=%b locked=%b cnt=%0d, want obs=000000000 locked=0 cnt=0",
                     obs(), locked, err_count);
        end
        step(1'b1, 4'b0110);
        step(1'b0, 4'd0);
        checks++;
        if (obs() !== 9'b1_0100_0000 || locked !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL first_sample: got obs=%b locked=%b cnt=%0d, want obs=101000000 locked=1 cnt=0",
                     obs(), locked, err_count);
        end
        step(1'b0, 4'd0);
        checks++;
        if (obs() !== 9'b0_0100_0000) begin
            errors++;
            $display("FAIL bubble_hold_bin: got obs=%b, want 001000000", obs());
        end
    endtask

    task automatic test_sweep();
        logic [8:0] exp_v;
        logic [3:0] b;
        do_reset();
        for (int i = 0; i <= 17; i++) begin
            b = 4'(i);
            step(i <= 16, to_gray(b));
            if (i >= 1) begin
                b     = 4'(i - 1);
                exp_v = {1'b1, b, 1'b0, (i >= 2), 1'b0, 1'b0};
                checks++;
                if (obs() !== exp_v || err_count !== 8'd0) begin
                    errors++;
                    $display("FAIL sweep[%0d]: got obs=%b cnt=%0d, want obs=%b cnt=0",
                             i - 1, obs(), err_count, exp_v);
                end
            end
        end
    endtask

    task automatic test_desc_hold_bubble();
        logic       vin [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] gin [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
        logic [8:0] exp_v [7] = '{9'b1_0011_0000,   // 3: first sample
                                  9'b1_0011_1000,   // 3: hold
                                  9'b0_0011_0000,   // bubble
                                  9'b1_0010_0010,   // 2: down
                                  9'b1_0001_0010,   // 1: down
                                  9'b1_0000_0010,   // 0: down
                                  9'b1_1111_0010};  // 15: down (wrap)
        do_reset();
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) step(vin[i], gin[i]);
            else       step(1'b0, 4'd0);
            if (i >= 1) begin
                checks++;
                if (obs() !== exp_v[i-1]) begin
                    errors++;
                    $display("FAIL desc[%0d]: got obs=%b, want %b", i - 1, obs(), exp_v[i-1]);
                end
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0010);
        checks++;
        if (obs() !== 9'b1_0010_0001 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL jump: got obs=%b cnt=%0d, want obs=100100001 cnt=1", obs(), err_count);
        end
        step(1'b0, 4'd0);
        checks++;
        if (obs() !== 9'b1_0011_0100 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL resync_up: got obs=%b cnt=%0d, want obs=100110100 cnt=1", obs(), err_count);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        for (int i = 0; i <= 300; i++) begin
            step(i < 300, (i % 2 == 1) ? 4'b0011 : 4'b0000);
            if (i >= 1) begin
                exp_cnt = (i - 1 > 255) ? 255 : i - 1;
                checks++;
                if (out_valid !== 1'b1 || err_jump !== (i >= 2) || err_count !== 8'(exp_cnt)) begin
                    errors++;
                    $display("FAIL saturate[%0d]: got valid=%b jump=%b cnt=%0d, want valid=1 jump=%b cnt=%0d",
                             i - 1, out_valid, err_jump, err_count, (i >= 2), exp_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 4'b0001);
        rst = 1'b1;
        step(1'b1, 4'b0101);
        rst = 1'b0;
        checks++;
        if (obs() !== 9'b0_0000_0000 || locked !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got obs=%b locked=%b cnt=%0d, want obs=000000000 locked=0 cnt=0",
                     obs(), locked, err_count);
        end
        step(1'b1, 4'b1111);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL discarded_sample: got valid=%b, want 0", out_valid);
        end
        step(1'b0, 4'd0);
        checks++;
        if (obs() !== 9'b1_1010_0000 || locked !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_first: got obs=%b locked=%b cnt=%0d, want obs=110100000 locked=1 cnt=0",
                     obs(), locked, err_count);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_gray  = 4'd0;
        test_reset();
        test_sweep();
        test_desc_hold_bubble();
        test_jump();
        test_saturation();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_ptr_monitor.md
# gray_ptr_monitor

Receive-side companion to the binary/Gray encoder pair. It accepts a stream of Gray-coded pointer samples, decodes each to binary and checks that each sample differs from the previously accepted one by at most one bit. It classifies every sample as hold, step-up, step-down or illegal jump, and keeps a saturating error count. It sits at the consumer end of a Gray-coded pointer/counter channel, for example the already-synchronised write pointer seen by a FIFO read side.

## Interface
- DATA_WIDTH, 4: width of the Gray/binary pointer; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_gray holds a sample this cycle.
- in_gray  input  DATA_WIDTH  Gray-coded pointer sample.
- out_valid  output  1  result registers hold a new result (one-cycle pulse per accepted sample).
- out_bin  output  DATA_WIDTH  binary decode of the sample.
- out_hold  output  1  sample equals the reference (Hamming distance 0).
- out_up  output  1  binary value is reference+1 mod 2^DATA_WIDTH.
- out_down  output  1  binary value is reference−1 mod 2^DATA_WIDTH.
- err_jump  output  1  Hamming distance to the reference is ≥2.
- err_count  output  8  saturating count of err_jump events.
- locked  output  1  a reference sample exists (state LOCK).

## Operation
- Two-stage pipeline:
  - S1 registers in_valid/in_gray into s1_valid/s1_gray.
  - S2 decodes and classifies s1_gray, then updates the outputs and the reference.
- Decode: out_bin[W−1] = g[W−1]; out_bin[i] = out_bin[i+1] ^ g[i], descending.
- State machine, 2 states:
  - SEEK (reset state): no reference exists.
    - On s1_valid, the sample becomes the reference, the state moves to LOCK, and out_valid=1.
    - In that cycle out_hold, out_up, out_down and err_jump are all 0, because the first sample is never classified.
  - LOCK: on s1_valid, compute d = popcount(s1_gray ^ ref_gray).
    - d=0: out_hold=1.
    - d=1: compare the decoded binary against ref_bin.
      - If it equals ref_bin+1 mod 2^W, out_up=1.
      - Otherwise (it is necessarily ref_bin−1 mod 2^W), out_down=1.
    - d≥2: err_jump=1, and err_count increments, saturating at 255.
    - In every case the sample becomes the new reference (resync on jump), and the state stays LOCK.
- Exactly one of out_hold/out_up/out_down/err_jump is 1 on each classified out_valid cycle.
- Wrap-around is legal:
  - For W=4, Gray 1000 (bin 15) → 0000 (bin 0) is out_up.
  - The reverse, 0000 → 1000, is out_down.
- in_valid=0 cycles are bubbles. They do not change the reference, the state or the counters, and out_valid=0 two cycles later.
- Classification outputs and out_valid are pulses, 0 on any cycle without a result. out_bin holds its last value between results.
- err_count and locked are level outputs.

## Timing
- Latency: a sample presented with in_valid at edge N appears on the outputs after edge N+1 (2-register pipeline; outputs valid in cycle N+2 relative to the presentation cycle N).
- Throughput: one sample per clock. Back-to-back samples are each compared against the immediately preceding accepted sample, with no stall.
- Reset (rst=1 at an edge): all of the following clear at that edge:
  - state → SEEK, s1_valid=0, ref cleared.
  - out_valid, out_bin, out_hold, out_up, out_down, err_jump all 0.
  - err_count=0, locked=0.
- A sample in flight when rst asserts is discarded. The first valid sample after rst deasserts becomes the new reference.
- rst has priority over in_valid on the same edge.
- err_count at 255 stays 255 on further jumps; err_jump still pulses.

## Test plan
- Reset then first sample (W=4):
  - Stimulus: rst for 2 cycles, then in_gray=0110 valid for one cycle.
  - Response: two cycles later out_valid=1, out_bin=0100, all classification flags 0, locked=1, err_count=0.
- Full ascending sweep:
  - Stimulus: drive Gray codes for bin 0..15 then 0 on consecutive cycles.
  - Response: out_bin tracks 0..15,0. out_up=1 on every result after the first, including the 15→0 wrap (1000→0000). err_count stays 0.
- Descending with holds and bubbles:
  - Stimulus: bin 3,3,(bubble),2,1,0,15.
  - Response: out_hold on the second 3, no out_valid for the bubble, then out_down on 2, 1, 0 and 15 (0000→1000).
- Illegal jump and resync:
  - Stimulus: Gray 0000 then 0011, then 0010.
  - Response: err_jump=1 with out_bin=0010 and err_count=1. The following 0010 (bin 3) is out_up relative to the new reference.
- Counter saturation:
  - Stimulus: alternate 0000/0011 for 300 samples.
  - Response: err_count reaches 255 and stays there; err_jump keeps pulsing after saturation.
- Reset mid-stream:
  - Stimulus: in LOCK, assert rst on the same edge as a valid 0101, then send 1111.
  - Response: no result for 0101. 1111 is treated as a first sample (flags 0, out_bin=1010), and err_count=0.
